// File: rtl/id_fwd_stage.sv
// Decode stage holding register with operand forwarding and load-use interlock.
// Resolves rs1/rs2 combinationally from the youngest matching writer and stalls while that writer's data is not final.
module id_fwd_stage #(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 64,
   parameter int NFWD      = 3,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 fs2ds_valid,
   output logic                 ds_allowin,
   input  logic [PAYLOAD_W-1:0] fs2ds_bus,
   output logic [PAYLOAD_W-1:0] ds_bus,
   output logic                 ds2es_valid,
   input  logic                 es_allowin,
   input  logic                 flush,
   input  logic [4:0]           raddr1,
   input  logic [4:0]           raddr2,
   input  logic                 use1,
   input  logic                 use2,
   input  logic [XLEN-1:0]      rf_rdata1,
   input  logic [XLEN-1:0]      rf_rdata2,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [5*NFWD-1:0]    fwd_dest,
   input  logic [XLEN*NFWD-1:0] fwd_data,
   input  logic [NFWD-1:0]      fwd_ok,
   output logic [XLEN-1:0]      rs1_value,
   output logic [XLEN-1:0]      rs2_value,
   output logic [CNT_W-1:0]     stall_cnt,
   input  logic                 stall_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 ds_valid;
   logic [PAYLOAD_W-1:0] ds_payload;
   logic                 op1_pend;
   logic                 op2_pend;
   logic                 hazard;
   logic                 ds_ready_go;

   // Walk oldest to youngest so the lowest-index match overrides; its fwd_ok alone decides pending.
   always_comb begin
      rs1_value = rf_rdata1;
      rs2_value = rf_rdata2;
      op1_pend  = 1'b0;
      op2_pend  = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && (fwd_dest[5*i +: 5] == raddr1) && (raddr1 != 5'd0)) begin
            rs1_value = fwd_data[XLEN*i +: XLEN];
            op1_pend  = ~fwd_ok[i];
         end
         if (fwd_we[i] && (fwd_dest[5*i +: 5] == raddr2) && (raddr2 != 5'd0)) begin
            rs2_value = fwd_data[XLEN*i +: XLEN];
            op2_pend  = ~fwd_ok[i];
         end
      end
      if (raddr1 == 5'd0) rs1_value = '0;
      if (raddr2 == 5'd0) rs2_value = '0;
   end

   // Handshake: a payload moves on any edge where its valid and the receiver's allowin are both 1;
   // valid never depends on the receiver's allowin, and flush removes the held instruction at once.
   assign hazard      = ds_valid & ((use1 & op1_pend) | (use2 & op2_pend));
   assign ds_ready_go = ~hazard;
   assign ds_allowin  = ~ds_valid | (ds_ready_go & es_allowin);
   assign ds2es_valid = ds_valid & ds_ready_go & ~flush;
   assign ds_bus      = ds_payload;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_valid <= 1'b0;
      end else if (flush) begin
         ds_valid <= 1'b0;
      end else if (ds_allowin) begin
         ds_valid <= fs2ds_valid;
      end
   end

   // Payload needs no reset: it is only observed while ds_valid is set.
   always_ff @(posedge clk) begin
      if (fs2ds_valid && ds_allowin && !flush) begin
         ds_payload <= fs2ds_bus;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (hazard && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
